// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, grant
// encoding and the watchdog counter width helper.
package mem_arb_pkg;

  localparam int DEFAULT_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  // Wide enough to hold the timeout value itself.
  function automatic int wd_width(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, shared memory port and stall/error
// outputs. slave = arbiter view, master = pipeline/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_dm;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_dm, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_dm, err
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Access watchdog: counts busy cycles without mem_ready; expired flags the
// cycle in which the count reaches TIMEOUT_CYC.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            WD_W  = wd_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (reset)       count_q <= '0;
    else if (clear)  count_q <= '0;
    else if (enable) count_q <= count_q + 1'b1;
  end

  assign expired = enable && (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-ported I/D memory between fetch and data
// stages. Optional round-robin tie-break: define MEM_ARB_RR_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  gnt_e              gnt;
  logic              grant, done, abort, if_v, dm_v;
  logic              wd_clear, wd_enable, expired;
  logic              mem_req_q, mem_we_q, if_ack_q, dm_ack_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
`ifdef MEM_ARB_RR_EN
  gnt_e              last_q;
`endif

  assign wd_enable = (state_q != IDLE) && !bus.mem_ready;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    gnt      = GNT_DM;
    grant    = 1'b0;
    done     = 1'b0;
    abort    = 1'b0;
    wd_clear = 1'b0;
    // A requester being acked this cycle is still holding req; ignore it.
    if_v     = bus.if_req && !if_ack_q;
    dm_v     = bus.dm_req && !dm_ack_q;
    case (state_q)
      IDLE: begin
        if (if_v || dm_v) begin
          grant    = 1'b1;
          wd_clear = 1'b1;
`ifdef MEM_ARB_RR_EN
          if (if_v && dm_v) gnt = (last_q == GNT_DM) ? GNT_IF : GNT_DM;
          else              gnt = dm_v ? GNT_DM : GNT_IF;
`else
          gnt = dm_v ? GNT_DM : GNT_IF;
`endif
          state_d = (gnt == GNT_IF) ? BUSY_IF : BUSY_DM;
        end
      end
      BUSY_IF, BUSY_DM: begin
        // mem_ready beats a coincident timeout.
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      err_q    <= 1'b0;
      if (grant) begin
        mem_req_q <= 1'b1;
        if (gnt == GNT_DM) begin
          mem_we_q    <= bus.dm_we;
          mem_addr_q  <= bus.dm_addr;
          mem_wdata_q <= bus.dm_wdata;
        end else begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= bus.if_addr;
          mem_wdata_q <= '0;
        end
      end
      if (done || abort) begin
        mem_req_q <= 1'b0;
        err_q     <= abort;
        if (state_q == BUSY_IF) begin
          if_ack_q   <= 1'b1;
          if_rdata_q <= done ? bus.mem_rdata : '0;
        end else begin
          dm_ack_q <= 1'b1;
          if (abort)          dm_rdata_q <= '0;
          else if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)      last_q <= GNT_DM;
    else if (grant) last_q <= gnt;
  end
`endif

  mem_arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (expired)
  );

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.err       = err_q;
  assign bus.stall_if  = bus.if_req && !if_ack_q;
  assign bus.stall_dm  = bus.dm_req && !dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random traffic with a
// responding memory, all checked against an owner/latency reference model.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  typedef enum int {NONE, SRC_IF, SRC_DM} src_e;
`ifdef MEM_ARB_RR_EN
  localparam src_e TIE_WIN = SRC_IF;
`else
  localparam src_e TIE_WIN = SRC_DM;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: which requester the port serves and for how long.
  src_e        owner = NONE;
  src_e        last_gnt = SRC_DM;
  int          busy_n = 0;
  int          lat_cur = 0;
  int          next_lat = 1;
  bit          rnd_lat = 0;
  bit          idle_noise = 0;
  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic        e_req = 0, e_we = 0, e_if_ack = 0, e_dm_ack = 0, e_err = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_if_rdata = 0, e_dm_rdata = 0;
  logic [31:0] mem_model [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick_lat();
    int r = $urandom_range(0, 9);
    if (r < 4) return 1;
    if (r < 8) return $urandom_range(2, TMO);
    return 0;  // never ready: watchdog abort
  endfunction

  // Memory side: ready on the lat_cur-th busy cycle; stores land in memory then.
  task automatic drive_memory();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    if (owner != NONE) begin
      if (busy_n + 1 == lat_cur) begin
        bus.mem_ready = 1'b1;
        if (cur_we) mem_model[cur_addr[5:2]] = cur_wdata;
        else        bus.mem_rdata = mem_model[cur_addr[5:2]];
      end
    end else if (idle_noise) begin
      bus.mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Advance expectations across one rising edge, using this cycle's inputs.
  task automatic model_step();
    bit   if_v, dm_v;
    src_e w;
    if (reset) begin
      owner = NONE; last_gnt = SRC_DM; busy_n = 0;
      {e_req, e_we, e_if_ack, e_dm_ack, e_err} = '0;
      e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_dm_rdata = 0;
      return;
    end
    if_v = bus.if_req && !e_if_ack;
    dm_v = bus.dm_req && !e_dm_ack;
    e_if_ack = 0; e_dm_ack = 0; e_err = 0;
    if (owner != NONE) begin
      busy_n++;
      if (bus.mem_ready || busy_n == TMO) begin
        e_err = !bus.mem_ready;
        if (owner == SRC_IF) begin
          e_if_ack = 1;
          e_if_rdata = bus.mem_ready ? bus.mem_rdata : 32'h0;
        end else begin
          e_dm_ack = 1;
          if (!bus.mem_ready) e_dm_rdata = 32'h0;
          else if (!cur_we)   e_dm_rdata = bus.mem_rdata;
        end
        owner = NONE;
        e_req = 0;
      end
    end else begin
      w = NONE;
      if (if_v && dm_v) begin
`ifdef MEM_ARB_RR_EN
        w = (last_gnt == SRC_DM) ? SRC_IF : SRC_DM;
`else
        w = SRC_DM;
`endif
      end else if (dm_v) w = SRC_DM;
      else if (if_v)     w = SRC_IF;
      if (w != NONE) begin
        owner = w; last_gnt = w; busy_n = 0;
        lat_cur = rnd_lat ? pick_lat() : next_lat;
        if (w == SRC_DM) begin
          cur_we = bus.dm_we; cur_addr = bus.dm_addr; cur_wdata = bus.dm_wdata;
        end else begin
          cur_we = 0; cur_addr = bus.if_addr; cur_wdata = 0;
        end
        e_req = 1; e_we = cur_we; e_addr = cur_addr; e_wdata = cur_wdata;
      end
    end
  endtask

  task automatic check_outputs();
    check("mem_req", bus.mem_req, e_req);
    if (e_req) begin
      check("mem_we", bus.mem_we, e_we);
      check("mem_addr", bus.mem_addr, e_addr);
      if (e_we) check("mem_wdata", bus.mem_wdata, e_wdata);
    end
    check("if_ack", bus.if_ack, e_if_ack);
    check("dm_ack", bus.dm_ack, e_dm_ack);
    check("err", bus.err, e_err);
    check("if_rdata", bus.if_rdata, e_if_rdata);
    check("dm_rdata", bus.dm_rdata, e_dm_rdata);
  endtask

  // One clock: respond, check stalls, predict, then sample on the falling edge.
  task automatic tick();
    drive_memory();
    #1;
    check("stall_if", bus.stall_if, bus.if_req && !e_if_ack);
    check("stall_dm", bus.stall_dm, bus.dm_req && !e_dm_ack);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] addr_of(input src_e s);
    return (s == SRC_DM) ? 32'h20 : 32'h0;
  endfunction

  function automatic logic ack_of(input src_e s);
    return (s == SRC_DM) ? bus.dm_ack : bus.if_ack;
  endfunction

  function automatic logic stall_of(input src_e s);
    return (s == SRC_DM) ? bus.stall_dm : bus.stall_if;
  endfunction

  task automatic set_req(input src_e s, input logic v);
    if (s == SRC_DM) bus.dm_req = v;
    else             bus.if_req = v;
  endtask

  initial begin
    int   n;
    src_e w1, w2;
    bit   if_act, dm_act;

    for (int i = 0; i < 16; i++) mem_model[i] = 32'h1000_0000 + 32'(i);
    mem_model[4]  = 32'hDEAD_BEEF;
    mem_model[12] = 32'hCAFE_F00D;
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    reset = 1;
    tick(); tick();
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    reset = 0;

    // Single fetch, memory ready on the first busy cycle.
    bus.if_req = 1; bus.if_addr = 32'h10; next_lat = 1;
    tick();
    check("fetch_mem_req", bus.mem_req, 1'b1);
    check("fetch_mem_addr", bus.mem_addr, 32'h10);
    check("fetch_mem_we", bus.mem_we, 1'b0);
    check("fetch_stall_c1", bus.stall_if, 1'b1);
    tick();
    check("fetch_ack_c2", bus.if_ack, 1'b1);
    check("fetch_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    check("fetch_stall_c2", bus.stall_if, 1'b0);
    bus.if_req = 0;
    tick();
    check("fetch_ack_pulse", bus.if_ack, 1'b0);

    // Three simultaneous rounds from a fresh reset (pointer starts at DM).
    reset = 1; tick(); reset = 0;
    for (int r = 0; r < 3; r++) begin
      w1 = TIE_WIN;
      w2 = (w1 == SRC_DM) ? SRC_IF : SRC_DM;
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'h55;
      bus.if_req = 1; bus.if_addr = 32'h0;
      tick();
      check("tie_first_addr", bus.mem_addr, addr_of(w1));
      check("tie_first_we", bus.mem_we, w1 == SRC_DM);
      tick();
      check("tie_first_ack", ack_of(w1), 1'b1);
      check("tie_loser_stall", stall_of(w2), 1'b1);
      tick();
      set_req(w1, 1'b0);
      check("tie_second_addr", bus.mem_addr, addr_of(w2));
      check("tie_second_req", bus.mem_req, 1'b1);
      tick();
      check("tie_second_ack", ack_of(w2), 1'b1);
      set_req(w2, 1'b0);
      tick();
    end

    // Memory wait up to the timeout boundary: ready on the last allowed cycle.
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h30; next_lat = TMO;
    tick();
    n = 0;
    while (bus.mem_req && n < 20) begin
      check("wait_addr_stable", bus.mem_addr, 32'h30);
      n++;
      tick();
    end
    check("wait_req_cycles", n, TMO);
    check("wait_ack", bus.dm_ack, 1'b1);
    check("wait_no_err", bus.err, 1'b0);
    check("wait_rdata", bus.dm_rdata, 32'hCAFE_F00D);
    bus.dm_req = 0;
    tick();

    // Watchdog abort: memory never answers.
    bus.dm_req = 1; bus.dm_addr = 32'h34; next_lat = 0;
    tick();
    n = 0;
    while (bus.mem_req && n < 20) begin n++; tick(); end
    check("tmo_req_cycles", n, TMO);
    check("tmo_ack", bus.dm_ack, 1'b1);
    check("tmo_err", bus.err, 1'b1);
    check("tmo_rdata", bus.dm_rdata, 32'h0);
    bus.dm_req = 0;
    bus.if_req = 1; bus.if_addr = 32'h10; next_lat = 2;
    tick();
    n = 0;
    while (!bus.if_ack && n < 20) begin n++; tick(); end
    check("post_tmo_ack", bus.if_ack, 1'b1);
    check("post_tmo_err", bus.err, 1'b0);
    check("post_tmo_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    bus.if_req = 0;
    tick();

    // Reset in the middle of a data access.
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h38; next_lat = 0;
    tick(); tick();
    check("rmid_busy", bus.mem_req, 1'b1);
    reset = 1;
    tick();
    reset = 0; bus.dm_req = 0;
    check("rmid_mem_req", bus.mem_req, 1'b0);
    check("rmid_mem_addr", bus.mem_addr, 32'h0);
    check("rmid_if_rdata", bus.if_rdata, 32'h0);
    check("rmid_dm_ack", bus.dm_ack, 1'b0);
    tick();
    check("rmid_no_late_ack", bus.dm_ack, 1'b0);
    bus.if_req = 1; bus.if_addr = 32'h10; next_lat = 1;
    tick(); tick();
    check("rmid_fetch_ack", bus.if_ack, 1'b1);
    check("rmid_fetch_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    bus.if_req = 0;
    tick();

    // Random traffic with noisy idle cycles and occasional resets.
    rnd_lat = 1; idle_noise = 1; if_act = 0; dm_act = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if (if_act && bus.if_ack) if_act = 0;
      if (dm_act && bus.dm_ack) dm_act = 0;
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1;
        bus.if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!dm_act && $urandom_range(0, 2) == 0) begin
        dm_act = 1;
        bus.dm_we = 1'($urandom_range(0, 1));
        bus.dm_addr = 32'($urandom_range(0, 15)) << 2;
        bus.dm_wdata = $urandom;
      end
      bus.if_req = if_act;
      bus.dm_req = dm_act;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single-ported unified instruction/data memory between the fetch stage and the memory stage of the five-stage RISC-V pipeline. Accepts one request per requester, grants one at a time, and sequences the shared memory port through a three-state FSM. Returns read data and a one-cycle acknowledge to the winner and produces per-requester stall signals for the pipeline's stall logic. A watchdog aborts a memory access that never completes.

## Interface
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- TIMEOUT_CYC, 255: maximum cycles to wait for mem_ready before aborting; must be ≥1.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  DATA_W  fetched word; valid when if_ack.
- if_ack  out  1  one-cycle completion pulse to fetch.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid when dm_ack.
- dm_ack  out  1  one-cycle completion pulse to memory stage.
- mem_req  out  1  shared-port request.
- mem_we  out  1  shared-port write enable.
- mem_addr  out  ADDR_W  shared-port address.
- mem_wdata  out  DATA_W  shared-port write data.
- mem_rdata  in  DATA_W  shared-port read data; sampled when mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.
- stall_if  out  1  if_req & ~if_ack.
- stall_dm  out  1  dm_req & ~dm_ack.
- err  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE: evaluate requests. Mask a requester whose ack is high this cycle. Grant a winner and move to BUSY_IF or BUSY_DM. Latch address, we and wdata into the port registers and set mem_req=1. With no request, stay in IDLE with mem_req=0.
- Tie-break (both requests unmasked): data wins. Round-robin applies only when configured (see Configuration).
- BUSY_x: hold mem_req, mem_we, mem_addr and mem_wdata constant.
  - On mem_ready=1: capture mem_rdata into x_rdata (into if_rdata for BUSY_IF; into dm_rdata for BUSY_DM loads), pulse x_ack next cycle, clear mem_req, return to IDLE.
  - A store leaves dm_rdata unchanged.
- Fetch is always a read: mem_we=0 in BUSY_IF.
- Watchdog: a counter clears on grant and increments each BUSY cycle without mem_ready. When it reaches TIMEOUT_CYC, abort:
  - mem_req drops.
  - x_ack and err pulse together next cycle.
  - x_rdata is set to 0.
  - FSM returns to IDLE.
  - mem_ready in the same cycle as the timeout wins: the access completes normally, no err.
- mem_ready while in IDLE is ignored.
- Reset, including mid-access:
  - FSM goes to IDLE.
  - mem_req, mem_we, if_ack, dm_ack and err are 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
  - Watchdog counter is 0; round-robin pointer points to DM.
  - The pending access is dropped without an ack; memory must tolerate the abandoned request.

## Timing
- Request seen in IDLE at cycle N → mem_req high from cycle N+1.
- Earliest mem_ready at cycle N+1 → ack at cycle N+2. Minimum latency is 2 cycles.
- The ack cycle is an IDLE cycle, so the next grant occurs in the same cycle. Back-to-back throughput is one access per 2 cycles plus memory wait.
- Requesters may deassert req in the cycle after ack; the IDLE mask makes holding req through the ack cycle harmless.
- A losing requester waits at least until the winner's ack cycle; its stall stays high throughout.
- All outputs are registered except stall_if and stall_dm, which are combinational from req and ack.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on ties. A 1-bit pointer records the last grantee and the other requester wins the next tie. The pointer resets to DM, so the first tie goes to IF.
- MEM_ARB_RR_EN undefined: fixed priority; dm always beats if. No pointer register is built.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_DM);
  - the grant encoding (GNT_IF, GNT_DM);
  - the watchdog width, computed as $clog2(TIMEOUT_CYC+1).
- One sub-module, mem_arb_watchdog, holds the counter: inputs clear and enable, output expired.

## Test plan
- Single fetch: if_req, if_addr=0x10, memory returns 0xDEADBEEF one cycle after mem_req → mem_addr=0x10, mem_we=0, if_ack at cycle 2 with if_rdata=0xDEADBEEF, stall_if high for cycles 0–1.
- Simultaneous requests, fixed priority: dm store to 0x20 with data 0x55 and fetch from 0x0 → dm served first (mem_we=1, mem_wdata=0x55); if granted on the dm_ack cycle; if_ack 2 cycles later.
- Simultaneous requests repeated three times with MEM_ARB_RR_EN → grant order IF, DM, IF.
- Memory wait: mem_ready withheld 5 cycles after mem_req → mem_req and mem_addr stable for 6 cycles; ack on the cycle after mem_ready.
- Timeout with TIMEOUT_CYC=4 and mem_ready never asserted → mem_req drops after 4 BUSY cycles; dm_ack and err pulse together; dm_rdata=0; the next request is served normally.
- Reset asserted during BUSY_DM → next cycle all outputs 0 and FSM in IDLE; no dm_ack; a fresh if_req completes normally.
